// File: rtl/colour_demodulator.sv
// colour_demodulator
// Measures a composite video sample stream over two windows and recovers the
// 64-entry palette colour code that produced it. The first window (MEAN)
// measures the average level, which gives the luma. The second window (PHASE)
// measures the peak-to-peak swing and the subcarrier phase at the first rising
// crossing of that average, which gives the hue. A free-running subcarrier NCO
// provides the phase reference, and it matches the transmit side.
//
// Ports:
//   clk        system clock (50 MHz)
//   reset      synchronous, active-high; aborts any measurement in progress
//   video      8-bit unsigned video sample, valid every clock
//   start      request a measurement (only honoured while idle)
//   busy       high whenever a measurement is in progress
//   done       one-cycle pulse when colourNum/amp have been updated
//   colourNum  {2'b00, luma[1:0], hue[3:0]}, held until the next done
//   amp        peak-to-peak amplitude seen in the phase window
module colour_demodulator #(
  parameter int          WIN_LOG2     = 6,
  parameter logic [23:0] FCW          = 24'd1201096,
  parameter logic [7:0]  PHASE_OFFSET = 8'h00,
  parameter logic [7:0]  CHROMA_MIN   = 8'h10,
  parameter logic [7:0]  L1_T         = 8'h50,
  parameter logic [7:0]  L2_T         = 8'h70,
  parameter logic [7:0]  L3_T         = 8'h90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] video,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] colourNum,
  output logic [7:0] amp
);

  localparam int SUM_W = 8 + WIN_LOG2;

  typedef enum logic [1:0] {IDLE, MEAN, PHASE, RESOLVE} state_t;

  state_t              state;
  state_t              state_next;
  logic [23:0]         acc;
  logic [7:0]          phase;
  logic [WIN_LOG2-1:0] cnt;
  logic                cnt_last;
  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    sum_total;
  logic [7:0]          mean;
  logic [7:0]          prev;
  logic [7:0]          vmin;
  logic [7:0]          vmax;
  logic [7:0]          captured;
  logic                found;
  logic                crossing;

  logic [7:0]          amp_calc;
  logic [1:0]          luma;
  logic [7:0]          phase_adj;
  logic [11:0]         hue_prod;
  logic [3:0]          hue;

  assign phase     = acc[23:16];
  assign cnt_last  = &cnt;
  assign sum_total = sum + {{WIN_LOG2{1'b0}}, video};
  assign crossing  = (prev < mean) && (video >= mean);

  // Next-state logic; busy is simply "not idle".
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start)    state_next = MEAN;
      MEAN:    if (cnt_last) state_next = PHASE;
      PHASE:   if (cnt_last) state_next = RESOLVE;
      RESOLVE:               state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // Result arithmetic. The hue is the top nibble of phase*12 (built as
  // phase*8 + phase*4, exact in 12 bits) plus one, so chroma hues are 1..12
  // and hue 0 is kept for "no chroma".
  always_comb begin
    amp_calc  = vmax - vmin;
    phase_adj = captured + PHASE_OFFSET;
    hue_prod  = {1'b0, phase_adj, 3'b000} + {2'b00, phase_adj, 2'b00};
    if (mean < L1_T)      luma = 2'd0;
    else if (mean < L2_T) luma = 2'd1;
    else if (mean < L3_T) luma = 2'd2;
    else                  luma = 2'd3;
    if (!found || (amp_calc < CHROMA_MIN)) hue = 4'd0;
    else                                   hue = hue_prod[11:8] + 4'd1;
  end

  // State register, NCO and measurement datapath. prev follows video every
  // cycle, so on PHASE entry it already holds the last MEAN sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= 24'd0;
      done      <= 1'b0;
      colourNum <= 8'h00;
      amp       <= 8'h00;
      cnt       <= '0;
      sum       <= '0;
      mean      <= 8'h00;
      prev      <= 8'h00;
      vmin      <= 8'hFF;
      vmax      <= 8'h00;
      captured  <= 8'h00;
      found     <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc + FCW;
      prev  <= video;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            sum   <= '0;
            vmin  <= 8'hFF;
            vmax  <= 8'h00;
            found <= 1'b0;
          end
        end
        MEAN: begin
          sum <= sum_total;
          cnt <= cnt + 1'b1;
          if (cnt_last) mean <= sum_total[SUM_W-1:WIN_LOG2];
        end
        PHASE: begin
          cnt <= cnt + 1'b1;
          if (video < vmin) vmin <= video;
          if (video > vmax) vmax <= video;
          // Only the first rising crossing in the window sets the phase.
          if (!found && crossing) begin
            captured <= phase;
            found    <= 1'b1;
          end
        end
        RESOLVE: begin
          colourNum <= {2'b00, luma, hue};
          amp       <= amp_calc;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_colour_demodulator.sv
// Testbench for colour_demodulator: table-driven measurements with constant
// and square-wave video (square waves derived from a bench copy of the NCO),
// plus hand-written protocol sequences for ignored starts and reset abort.
// A second instance with PHASE_OFFSET=8'h80 shares all inputs.
module tb_colour_demodulator;

  localparam logic [23:0] FCW = 24'd1201096;

  logic       clk;
  logic       reset;
  logic [7:0] video;
  logic       start;
  logic       busy,  busy2;
  logic       done,  done2;
  logic [7:0] colourNum, colourNum2;
  logic [7:0] amp, amp2;

  int         compared;
  int         mismatched;

  int         mode;
  logic [7:0] hiLevel;
  logic [7:0] loLevel;
  logic [23:0] tbAcc;
  logic [7:0]  tbPhase;
  logic [7:0]  shiftedPhase;

  typedef struct {
    int         mode;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] expColour;
    logic [7:0] expColour2;
    logic [7:0] expAmp;
  } vec_t;

  vec_t vecs[12];

  colour_demodulator dut (
    .clk(clk), .reset(reset), .video(video), .start(start),
    .busy(busy), .done(done), .colourNum(colourNum), .amp(amp)
  );

  colour_demodulator #(.PHASE_OFFSET(8'h80)) dut2 (
    .clk(clk), .reset(reset), .video(video), .start(start),
    .busy(busy2), .done(done2), .colourNum(colourNum2), .amp(amp2)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Bench copy of the subcarrier NCO, reset alongside the DUT.
  always @(posedge clk) begin
    if (reset) tbAcc <= 24'd0;
    else       tbAcc <= tbAcc + FCW;
  end

  assign tbPhase      = tbAcc[23:16];
  assign shiftedPhase = tbPhase + 8'h80;

  // Video source: mode 0 constant, mode 1 high when (phase+0x80) < 128,
  // mode 2 high when phase < 128.
  always @* begin
    case (mode)
      1:       video = shiftedPhase[7] ? loLevel : hiLevel;
      2:       video = tbPhase[7]      ? loLevel : hiLevel;
      default: video = hiLevel;
    endcase
  end

  task automatic applyStimulus(input int m, input logic [7:0] hi, input logic [7:0] lo);
    mode    = m;
    hiLevel = hi;
    loLevel = lo;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Called at a negedge; start is high for the current cycle N.
  task automatic runMeasure(input string name, input logic [7:0] expC,
                            input logic [7:0] expC2, input logic [7:0] expA);
    int cycles;
    bit busyOk;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    busyOk = 1'b1;
    while (!done && cycles < 200) begin
      if (!busy) busyOk = 1'b0;
      @(negedge clk);
      cycles++;
    end
    checkOutput({name, " latency"}, cycles, 130);
    checkOutput({name, " busy_during"}, {31'd0, busyOk}, 1);
    checkOutput({name, " busy_at_done"}, {31'd0, busy}, 0);
    checkOutput({name, " done2"}, {31'd0, done2}, 1);
    checkOutput({name, " colourNum"}, {24'd0, colourNum}, {24'd0, expC});
    checkOutput({name, " colourNum_off80"}, {24'd0, colourNum2}, {24'd0, expC2});
    checkOutput({name, " amp"}, {24'd0, amp}, {24'd0, expA});
  endtask

  initial begin
    int doneCount;
    int firstDone;

    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    start      = 1'b0;
    applyStimulus(0, 8'h40, 8'h40);

    // Vector table: {mode, hi, lo, colour, colour with offset 0x80, amp}
    vecs[0]  = '{0, 8'h40, 8'h40, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{0, 8'hA0, 8'hA0, 8'h30, 8'h30, 8'h00};
    vecs[2]  = '{1, 8'h70, 8'h50, 8'h17, 8'h11, 8'h20};
    vecs[3]  = '{2, 8'h70, 8'h50, 8'h11, 8'h17, 8'h20};
    vecs[4]  = '{1, 8'h68, 8'h58, 8'h17, 8'h11, 8'h10};
    vecs[5]  = '{1, 8'h67, 8'h59, 8'h10, 8'h10, 8'h0E};
    vecs[6]  = '{0, 8'h4F, 8'h4F, 8'h00, 8'h00, 8'h00};
    vecs[7]  = '{0, 8'h50, 8'h50, 8'h10, 8'h10, 8'h00};
    vecs[8]  = '{0, 8'h6F, 8'h6F, 8'h10, 8'h10, 8'h00};
    vecs[9]  = '{0, 8'h70, 8'h70, 8'h20, 8'h20, 8'h00};
    vecs[10] = '{0, 8'h8F, 8'h8F, 8'h20, 8'h20, 8'h00};
    vecs[11] = '{0, 8'h90, 8'h90, 8'h30, 8'h30, 8'h00};

    repeat (3) @(negedge clk);
    checkOutput("reset busy", {31'd0, busy}, 0);
    checkOutput("reset done", {31'd0, done}, 0);
    checkOutput("reset colourNum", {24'd0, colourNum}, 0);
    checkOutput("reset amp", {24'd0, amp}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Each measurement starts in the done cycle of the previous one, which
    // also exercises back-to-back acceptance.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].hi, vecs[i].lo);
      runMeasure($sformatf("vec%0d", i), vecs[i].expColour, vecs[i].expColour2, vecs[i].expAmp);
    end

    // Extra starts at N+10 and N+100 must be ignored, not queued.
    applyStimulus(0, 8'hA0, 8'hA0);
    start     = 1'b1;
    doneCount = 0;
    firstDone = -1;
    for (int c = 1; c <= 280; c++) begin
      @(negedge clk);
      start = (c == 10 || c == 100);
      if (done) begin
        doneCount++;
        if (firstDone < 0) firstDone = c;
      end
    end
    start = 1'b0;
    checkOutput("ignored_start done_count", doneCount, 1);
    checkOutput("ignored_start done_cycle", firstDone, 130);
    checkOutput("ignored_start colourNum", {24'd0, colourNum}, 32'h30);

    // Reset at N+70 aborts the measurement; outputs cleared, no done.
    applyStimulus(1, 8'h70, 8'h50);
    start = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort busy", {31'd0, busy}, 0);
    checkOutput("abort done", {31'd0, done}, 0);
    checkOutput("abort colourNum", {24'd0, colourNum}, 0);
    checkOutput("abort amp", {24'd0, amp}, 0);
    reset     = 1'b0;
    doneCount = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("abort no_done", doneCount, 0);

    // Fresh measurement after reset.
    runMeasure("after_reset", 8'h17, 8'h11, 8'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/colour_demodulator.md
# colour_demodulator

Measures an 8-bit composite video sample stream over a fixed window and recovers the 64-entry palette colour code (luma in bits 5:4, hue in bits 3:0) that produced it. The block is the receive-side counterpart of the colour synthesis path. It runs its own 3579545 Hz subcarrier phase accumulator, free-running from reset on the 50 MHz clock, so its phase reference matches the transmit side. Typical use is loopback self-test and palette calibration, with the DAC output fed back through an ADC.

## Interface
- WIN_LOG2, 6: window length is 2**WIN_LOG2 samples (64).
- FCW, 24'd1201096: subcarrier frequency control word for 3579545 Hz at 50 MHz.
- PHASE_OFFSET, 8'h00: added mod 256 to the captured phase before hue quantisation.
- CHROMA_MIN, 8'h10: minimum peak-to-peak amplitude treated as chroma.
- L1_T, 8'h50 / L2_T, 8'h70 / L3_T, 8'h90: luma thresholds on the window mean.
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- video  in  8  unsigned video sample, valid every clock.
- start  in  1  request a measurement; sampled only in IDLE.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse; colourNum and amp are valid from this cycle on.
- colourNum  out  8  {2'b00, luma[1:0], hue[3:0]}; held until the next done.
- amp  out  8  peak-to-peak amplitude (max - min) from the PHASE window; held until the next done.

## Operation
- NCO: 24-bit accumulator, reset to 0, adds FCW every cycle including IDLE. Wraps mod 2^24. phase = acc[23:16].
- States: IDLE, MEAN, PHASE, RESOLVE.
  - IDLE -> MEAN when start=1.
  - MEAN -> PHASE after 2**WIN_LOG2 samples.
  - PHASE -> RESOLVE after 2**WIN_LOG2 samples.
  - RESOLVE -> IDLE unconditionally, asserting done.
- MEAN:
  - Sum 2**WIN_LOG2 samples in a (8+WIN_LOG2)-bit accumulator, with no overflow.
  - mean = sum >> WIN_LOG2, truncated.
- PHASE:
  - Track the running min and max of video.
  - prev holds the previous sample; its initial value on PHASE entry is the last MEAN sample.
  - A rising crossing is prev < mean && video >= mean. On the first rising crossing only, capture phase from the same cycle and set a found flag.
  - Later crossings are ignored.
- RESOLVE:
  - amp = max - min.
  - luma: 0 if mean < L1_T; 1 if mean < L2_T; 2 if mean < L3_T; else 3.
  - If found=0 or amp < CHROMA_MIN: hue = 0.
  - Otherwise hue = (((captured + PHASE_OFFSET) mod 256) * 12 >> 8) + 1, giving range 1..12.
  - The multiply is 12-bit exact, implemented as shift-add.
- start while busy is ignored; no queueing.
- Accumulators, min/max and the found flag are cleared on IDLE -> MEAN. Reset values are not relied on.

## Timing
- Reset values:
  - busy=0, done=0, colourNum=8'h00, amp=8'h00.
  - state=IDLE, NCO acc=0.
- Reset takes priority in any state and aborts a measurement in progress.
  - No done is produced for the aborted measurement.
  - Outputs return to their reset values on the next edge.
- Cycle budget, with start high in cycle N:
  - MEAN samples video in cycles N+1 .. N+64.
  - PHASE samples video in cycles N+65 .. N+128.
  - RESOLVE occupies cycle N+129.
  - done=1 and new outputs are visible in cycle N+130. busy=1 in cycles N+1 .. N+129.
- Back-to-back: start high in cycle N+130 (done cycle, state IDLE) is accepted. The minimum measurement period is 130 cycles.
- The captured phase is the acc[23:16] value presented in the same cycle as the crossing sample, with no pipeline skew.

## Test plan
- Constant video=8'h40, one start:
  - Required: done exactly 130 cycles after start, colourNum=8'h00, amp=8'h00.
- Constant video=8'hA0:
  - Required: colourNum=8'h30 (luma 3, hue 0, no chroma).
- Square-wave video from a bench copy of the same NCO: 8'h70 when ((phase+8'h80) mod 256) < 128, else 8'h50.
  - Required: amp=8'h20 and colourNum=8'h17.
  - Reason: mean lies between 8'h50 and 8'h70, the captured phase falls in 8'h80..8'h91, giving hue 7 and luma 1.
- Same square wave with offset 8'h00:
  - Required: colourNum=8'h11 (hue 1).
  - With the same wave and PHASE_OFFSET=8'h80: colourNum=8'h17.
- Square wave with amplitude 8'h58/8'h68 (peak-to-peak 8'h10, equal to CHROMA_MIN) gives hue != 0.
  - Amplitude 8'h59/8'h67 (peak-to-peak 8'h0E) gives hue 0 and amp=8'h0E.
- Protocol checks:
  - start pulsed again at cycles N+10 and N+100: ignored, exactly one done at N+130.
  - reset asserted at N+70: busy=0 next cycle, no done, colourNum=8'h00.
  - A fresh start after reset completes normally.
